// File: rtl/regfile_sb.sv
// NRD-read / 1-write register file with EX/MEM/WB forwarding, load-use stall and a
// pending-load scoreboard. Define REGFILE_WB_BYPASS_EN to forward WB write data to reads.
module regfile_sb #(
   parameter  int unsigned XLEN = 32,
   parameter  int unsigned NREG = 32,
   parameter  int unsigned NRD  = 2,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_we_i,
   input  logic [AW-1:0]        wb_waddr_i,
   input  logic [XLEN-1:0]      wb_wdata_i,
   input  logic                 wb_load_i,
   input  logic                 mem_we_i,
   input  logic [AW-1:0]        mem_waddr_i,
   input  logic [XLEN-1:0]      mem_wdata_i,
   input  logic                 mem_load_i,
   input  logic                 ex_we_i,
   input  logic [AW-1:0]        ex_waddr_i,
   input  logic [XLEN-1:0]      ex_alu_i,
   input  logic                 ex_load_i,
   input  logic                 lsu_issue_i,
   input  logic [AW-1:0]        lsu_rd_i,
   input  logic [NRD-1:0]       re_i,
   input  logic [NRD*AW-1:0]    raddr_i,
   output logic [NRD*XLEN-1:0]  rdata_o,
   output logic                 stallreq_o,
   output logic [NREG-1:0]      pending_o
);

   logic [XLEN-1:0]     regs_q [NREG];
   logic [XLEN-1:0]     regs_d [NREG];
   logic [NREG-1:0]     pending_q;
   logic [NREG-1:0]     pending_d;
   logic [NRD*XLEN-1:0] rdata_c;
   logic [NRD-1:0]      stall_c;
   logic [AW-1:0]       rd_addr;
   logic [XLEN-1:0]     rd_word;

   // Architectural write; register 0 is never written so it stays zero.
   always_comb begin : write_next
      regs_d = regs_q;
      if (wb_we_i && (wb_waddr_i != '0)) begin
         regs_d[wb_waddr_i] = wb_wdata_i;
      end
   end

   // Scoreboard: clear first so a same-cycle issue to the same register wins.
   always_comb begin : pending_next
      pending_d = pending_q;
      if (wb_we_i && wb_load_i) begin
         pending_d[wb_waddr_i] = 1'b0;
      end
      if (lsu_issue_i && (lsu_rd_i != '0)) begin
         pending_d[lsu_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin : state_regs
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         pending_q <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
      end
   end

   // Per-port read: youngest forwarding source first, then scoreboard, then array.
   always_comb begin : read_ports
      rdata_c = '0;
      stall_c = '0;
      rd_addr = '0;
      rd_word = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         rd_addr = raddr_i[k*AW +: AW];
         rd_word = '0;
         if (!re_i[k] || (rd_addr == '0)) begin
            rd_word = '0;
         end else if (ex_we_i && (rd_addr == ex_waddr_i)) begin
            if (ex_load_i) begin
               stall_c[k] = 1'b1;
            end else begin
               rd_word = ex_alu_i;
            end
         end else if (mem_we_i && (rd_addr == mem_waddr_i)) begin
            if (mem_load_i) begin
               stall_c[k] = 1'b1;
            end else begin
               rd_word = mem_wdata_i;
            end
         end else if (wb_we_i && (rd_addr == wb_waddr_i)) begin
`ifdef REGFILE_WB_BYPASS_EN
            rd_word = wb_wdata_i;
`else
            stall_c[k] = 1'b1;
`endif
         end else if (pending_q[rd_addr]) begin
            stall_c[k] = 1'b1;
         end else begin
            rd_word = regs_q[rd_addr];
         end
         rdata_c[k*XLEN +: XLEN] = rd_word;
      end
   end

   assign rdata_o    = rst ? '0 : rdata_c;
   assign stallreq_o = !rst && (|stall_c);
   assign pending_o  = pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations are queued with the stimulus and
// drained on the falling edge. Follows REGFILE_WB_BYPASS_EN for WB-hit expectations.
module tb_regfile_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned AW   = 5;

   localparam int K_DATA  = 0;
   localparam int K_STALL = 1;
   localparam int K_PBIT  = 2;
   localparam int K_PVEC  = 3;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                wb_we_i, wb_load_i, mem_we_i, mem_load_i, ex_we_i, ex_load_i, lsu_issue_i;
   logic [AW-1:0]       wb_waddr_i, mem_waddr_i, ex_waddr_i, lsu_rd_i;
   logic [XLEN-1:0]     wb_wdata_i, mem_wdata_i, ex_alu_i;
   logic [NRD-1:0]      re_i;
   logic [NRD*AW-1:0]   raddr_i;
   logic [NRD*XLEN-1:0] rdata_o;
   logic                stallreq_o;
   logic [NREG-1:0]     pending_o;

   typedef struct {
      string           name;
      int              kind;
      int              idx;
      logic [XLEN-1:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk(clk), .rst(rst),
      .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_load_i(wb_load_i),
      .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .mem_load_i(mem_load_i),
      .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_alu_i(ex_alu_i), .ex_load_i(ex_load_i),
      .lsu_issue_i(lsu_issue_i), .lsu_rd_i(lsu_rd_i),
      .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
      .stallreq_o(stallreq_o), .pending_o(pending_o)
   );

   always #5 clk = ~clk;

   task automatic idle();
      wb_we_i = 0; wb_waddr_i = '0; wb_wdata_i = '0; wb_load_i = 0;
      mem_we_i = 0; mem_waddr_i = '0; mem_wdata_i = '0; mem_load_i = 0;
      ex_we_i = 0; ex_waddr_i = '0; ex_alu_i = '0; ex_load_i = 0;
      lsu_issue_i = 0; lsu_rd_i = '0;
      re_i = '0; raddr_i = '0;
   endtask

   task automatic rd(input int port, input logic [AW-1:0] a);
      re_i[port] = 1'b1;
      raddr_i[port*AW +: AW] = a;
   endtask

   task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic ld);
      wb_we_i = 1'b1; wb_waddr_i = a; wb_wdata_i = d; wb_load_i = ld;
   endtask

   task automatic push(input string n, input int kind, input int idx, input logic [XLEN-1:0] v);
      exp_t e;
      e.name = n; e.kind = kind; e.idx = idx; e.val = v;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      logic [XLEN-1:0] got;
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         idle();
         case (s)
            0: begin rd(0, 5); rd(1, 9);
                     push("rst_stall", K_STALL, 0, 0); push("rst_d0", K_DATA, 0, 0);
                     push("rst_d1", K_DATA, 1, 0); push("rst_pvec", K_PVEC, 0, 0); end
            1: begin rst = 0; wb(5, 32'h55, 0); lsu_issue_i = 1; lsu_rd_i = 20;
                     push("pend20_before_edge", K_PBIT, 20, 0); end
            2: begin rd(0, 20); rd(1, 5);
                     push("pend20_stall", K_STALL, 0, 1); push("x5_read", K_DATA, 1, 32'h55);
                     push("pend20_set", K_PBIT, 20, 1); end
            3: begin rst = 1; rd(0, 20); rd(1, 5);
                     push("async_rst_stall", K_STALL, 0, 0); push("async_rst_d0", K_DATA, 0, 0);
                     push("async_rst_d1", K_DATA, 1, 0); push("async_rst_pvec", K_PVEC, 0, 0); end
            default: begin rst = 0; rd(0, 20); rd(1, 5);
                     push("post_rst_stall", K_STALL, 0, 0); push("post_rst_x20", K_DATA, 0, 0);
                     push("post_rst_x5", K_DATA, 1, 0); end
         endcase
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
               K_DATA:  got = rdata_o[e.idx*XLEN +: XLEN];
               K_STALL: got = XLEN'(stallreq_o);
               K_PBIT:  got = XLEN'(pending_o[e.idx]);
               default: got = XLEN'(pending_o);
            endcase
            n_total++;
            if (got !== e.val) $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.val);
            else n_pass++;
         end
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      logic [XLEN-1:0] got;
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); #1;
         idle();
         case (s)
            0: wb(3, 32'hDEADBEEF, 0);
            1: begin rd(1, 3);
                     push("x3_read", K_DATA, 1, 32'hDEADBEEF); push("x3_stall", K_STALL, 0, 0); end
            2: begin wb(0, 32'h1234, 0); rd(0, 0);
                     push("x0_wb_hit", K_DATA, 0, 0); push("x0_wb_stall", K_STALL, 0, 0); end
            default: begin rd(0, 0); rd(1, 0);
                     push("x0_read_p0", K_DATA, 0, 0); push("x0_read_p1", K_DATA, 1, 0);
                     push("x0_stall", K_STALL, 0, 0); end
         endcase
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
               K_DATA:  got = rdata_o[e.idx*XLEN +: XLEN];
               K_STALL: got = XLEN'(stallreq_o);
               K_PBIT:  got = XLEN'(pending_o[e.idx]);
               default: got = XLEN'(pending_o);
            endcase
            n_total++;
            if (got !== e.val) $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.val);
            else n_pass++;
         end
      end
   endtask

   task automatic test_priority();
      exp_t e;
      logic [XLEN-1:0] got;
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); #1;
         idle();
         rd(0, 7); rd(1, 7);
         if (s == 0) begin ex_we_i = 1; ex_waddr_i = 7; ex_alu_i = 32'h11; end
         if (s <= 1) begin mem_we_i = 1; mem_waddr_i = 7; mem_wdata_i = 32'h22; end
         if (s <= 2) wb(7, 32'h33, 0);
         case (s)
            0: begin push("prio_ex_p0", K_DATA, 0, 32'h11); push("prio_ex_p1", K_DATA, 1, 32'h11);
                     push("prio_ex_stall", K_STALL, 0, 0); end
            1: begin push("prio_mem_p0", K_DATA, 0, 32'h22); push("prio_mem_p1", K_DATA, 1, 32'h22);
                     push("prio_mem_stall", K_STALL, 0, 0); end
            2: begin
                  if (BYP) begin
                     push("prio_wb_p0", K_DATA, 0, 32'h33); push("prio_wb_stall", K_STALL, 0, 0);
                  end else begin
                     push("prio_wb_stall", K_STALL, 0, 1);
                  end
               end
            default: begin push("x7_reg", K_DATA, 1, 32'h33); push("x7_stall", K_STALL, 0, 0); end
         endcase
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
               K_DATA:  got = rdata_o[e.idx*XLEN +: XLEN];
               K_STALL: got = XLEN'(stallreq_o);
               K_PBIT:  got = XLEN'(pending_o[e.idx]);
               default: got = XLEN'(pending_o);
            endcase
            n_total++;
            if (got !== e.val) $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.val);
            else n_pass++;
         end
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      logic [XLEN-1:0] got;
      for (int s = 0; s < 6; s++) begin
         @(posedge clk); #1;
         idle();
         case (s)
            0: begin ex_we_i = 1; ex_load_i = 1; ex_waddr_i = 9;
                     mem_we_i = 1; mem_waddr_i = 9; mem_wdata_i = 32'h99; rd(0, 9);
                     push("ex_load_stall", K_STALL, 0, 1); end
            1: begin mem_we_i = 1; mem_load_i = 1; mem_waddr_i = 9; rd(0, 9);
                     push("mem_load_stall", K_STALL, 0, 1); end
            2: begin ex_we_i = 1; ex_load_i = 1; ex_waddr_i = 9; rd(0, 10);
                     push("other_reg_stall", K_STALL, 0, 0); push("other_reg_data", K_DATA, 0, 0); end
            3: begin ex_we_i = 1; ex_load_i = 1; ex_waddr_i = 0; rd(0, 0);
                     push("x0_load_stall", K_STALL, 0, 0); end
            4: begin ex_we_i = 1; ex_load_i = 1; ex_waddr_i = 9; raddr_i[AW-1:0] = 9;
                     push("re_off_stall", K_STALL, 0, 0); push("re_off_data", K_DATA, 0, 0); end
            default: begin ex_load_i = 1; ex_waddr_i = 9; ex_alu_i = 32'h77; rd(0, 9);
                     push("ex_we_off_stall", K_STALL, 0, 0); push("ex_we_off_data", K_DATA, 0, 0); end
         endcase
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
               K_DATA:  got = rdata_o[e.idx*XLEN +: XLEN];
               K_STALL: got = XLEN'(stallreq_o);
               K_PBIT:  got = XLEN'(pending_o[e.idx]);
               default: got = XLEN'(pending_o);
            endcase
            n_total++;
            if (got !== e.val) $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.val);
            else n_pass++;
         end
      end
   endtask

   task automatic test_scoreboard();
      exp_t e;
      logic [XLEN-1:0] got;
      for (int s = 0; s < 10; s++) begin
         @(posedge clk); #1;
         idle();
         if (s == 0) begin
            lsu_issue_i = 1; lsu_rd_i = 12;
            push("x12_pend_pre", K_PBIT, 12, 0);
         end else if (s <= 5) begin
            rd(0, 12);
            push($sformatf("x12_stall_c%0d", s), K_STALL, 0, 1);
            push($sformatf("x12_pend_c%0d", s), K_PBIT, 12, 1);
         end else if (s == 6) begin
            wb(12, 32'hCAFE, 1); rd(0, 12);
            push("x12_pend_at_wb", K_PBIT, 12, 1);
            if (BYP) begin
               push("x12_wb_stall", K_STALL, 0, 0); push("x12_wb_data", K_DATA, 0, 32'hCAFE);
            end else begin
               push("x12_wb_stall", K_STALL, 0, 1);
            end
         end else if (s == 7) begin
            rd(0, 12);
            push("x12_after_stall", K_STALL, 0, 0); push("x12_after_data", K_DATA, 0, 32'hCAFE);
            push("x12_pend_clr", K_PBIT, 12, 0);
         end else if (s == 8) begin
            lsu_issue_i = 1; lsu_rd_i = 0;
         end else begin
            push("x0_issue_pvec", K_PVEC, 0, 0);
         end
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
               K_DATA:  got = rdata_o[e.idx*XLEN +: XLEN];
               K_STALL: got = XLEN'(stallreq_o);
               K_PBIT:  got = XLEN'(pending_o[e.idx]);
               default: got = XLEN'(pending_o);
            endcase
            n_total++;
            if (got !== e.val) $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.val);
            else n_pass++;
         end
      end
   endtask

   task automatic test_collision();
      exp_t e;
      logic [XLEN-1:0] got;
      for (int s = 0; s < 11; s++) begin
         @(posedge clk); #1;
         idle();
         case (s)
            0: begin lsu_issue_i = 1; lsu_rd_i = 4; end
            1: begin lsu_issue_i = 1; lsu_rd_i = 4; push("x4_repend", K_PBIT, 4, 1); end
            2: begin lsu_issue_i = 1; lsu_rd_i = 4; wb(4, 32'h44, 1); rd(0, 4);
                     if (BYP) begin
                        push("coll_stall", K_STALL, 0, 0); push("coll_data", K_DATA, 0, 32'h44);
                     end else begin
                        push("coll_stall", K_STALL, 0, 1);
                     end
               end
            3: begin rd(0, 4); push("coll_set_wins", K_PBIT, 4, 1); push("coll_still_stall", K_STALL, 0, 1); end
            4: begin wb(4, 32'h45, 1); rd(1, 4);
                     if (BYP) begin
                        push("x4_clr_stall", K_STALL, 0, 0); push("x4_clr_data", K_DATA, 1, 32'h45);
                     end else begin
                        push("x4_clr_stall", K_STALL, 0, 1);
                     end
               end
            5: begin rd(1, 4); push("x4_read", K_DATA, 1, 32'h45); push("x4_read_stall", K_STALL, 0, 0);
                     push("x4_pend_clr", K_PBIT, 4, 0); end
            6: begin lsu_issue_i = 1; lsu_rd_i = 8; end
            7: wb(8, 32'h88, 0);
            8: begin rd(0, 8); push("nonload_wb_keeps_pend", K_PBIT, 8, 1); push("x8_stall", K_STALL, 0, 1); end
            9: wb(8, 32'h89, 1);
            default: begin rd(0, 8); push("x8_data", K_DATA, 0, 32'h89); push("final_pvec", K_PVEC, 0, 0); end
         endcase
         @(negedge clk);
         while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
               K_DATA:  got = rdata_o[e.idx*XLEN +: XLEN];
               K_STALL: got = XLEN'(stallreq_o);
               K_PBIT:  got = XLEN'(pending_o[e.idx]);
               default: got = XLEN'(pending_o);
            endcase
            n_total++;
            if (got !== e.val) $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.val);
            else n_pass++;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_write_read();
      test_priority();
      test_load_use();
      test_scoreboard();
      test_collision();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the ID-stage register file: NRD read ports, one clocked write port, EX/MEM/WB operand forwarding and load-use stall generation.
- Adds a per-register pending-load scoreboard, so loads handed to a variable-latency memory unit stall dependent reads until their writeback.
- Sits between ID (read ports), EX/MEM/WB (forward sources) and stallctrl (stallreq_o).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers. Register 0 is hardwired to zero.
- NRD, 2, number of read ports.
- AW (localparam), $clog2(NREG), register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_we_i  in  1  WB write enable.
- wb_waddr_i  in  AW  WB destination register.
- wb_wdata_i  in  XLEN  WB write data.
- wb_load_i  in  1  WB write is the completion of an outstanding load.
- mem_we_i  in  1  MEM-stage write enable.
- mem_waddr_i  in  AW  MEM-stage destination register.
- mem_wdata_i  in  XLEN  MEM-stage result.
- mem_load_i  in  1  MEM-stage instruction is a load.
- ex_we_i  in  1  EX-stage write enable.
- ex_waddr_i  in  AW  EX-stage destination register.
- ex_alu_i  in  XLEN  EX-stage ALU result.
- ex_load_i  in  1  EX-stage instruction is a load.
- lsu_issue_i  in  1  load accepted by the LSU this cycle.
- lsu_rd_i  in  AW  destination register of the issued load.
- re_i  in  NRD  per-port read enable.
- raddr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rdata_o  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- stallreq_o  out  1  stall request to stallctrl.
- pending_o  out  NREG  scoreboard bit vector, for debug and trace.

Behaviour:
- Reset (rst=1, asynchronous):
  - All regs[] and pending[] clear to 0.
  - rdata_o and stallreq_o forced to 0 while rst is high.
  - pending_o = 0.
- Write: on posedge clk, if wb_we_i=1 and wb_waddr_i!=0, regs[wb_waddr_i] <= wb_wdata_i. Writes to register 0 are dropped.
- Scoreboard, registered on posedge clk:
  - Set: lsu_issue_i=1 and lsu_rd_i!=0 sets pending[lsu_rd_i].
  - Clear: wb_we_i=1 and wb_load_i=1 clears pending[wb_waddr_i].
  - Same register set and cleared in one cycle: set wins (the issued load is newer).
  - Issue to an already-pending register: the bit stays 1.
- Read, combinational, for each port k, first match wins:
  1. re_i[k]=0 -> 0.
  2. raddr=0 -> 0. Register 0 is never forwarded and never stalls.
  3. ex_we_i and addr==ex_waddr_i -> stall if ex_load_i, else ex_alu_i.
  4. mem_we_i and addr==mem_waddr_i -> stall if mem_load_i, else mem_wdata_i.
  5. wb_we_i and addr==wb_waddr_i -> wb_wdata_i.
  6. pending[addr]=1 -> stall.
  7. Otherwise regs[addr].
- Forwarding priority is youngest-first (EX > MEM > WB). An older stage never shadows a newer one.
- Rule 5 precedes rule 6, so the WB write that clears a pending bit forwards its data in the same cycle, with no stall.
- stallreq_o = OR of all port stall conditions. rdata_o for a stalling port is don't-care; the bench must not check it.
- Latency:
  - Read: 0 cycles.
  - Write visible through regs[] from the cycle after the WB edge.
  - Pending visible to reads from the cycle after the lsu_issue_i edge.
- Reset mid-operation: all pending loads are discarded, and stall deasserts immediately (asynchronously).

Optional Feature:
- REGFILE_WB_BYPASS_EN defined: rule 5 is active as described.
- Not defined: rule 5 is removed. A read hitting an enabled WB write (addr!=0) asserts stallreq_o for that cycle, and returns regs[] on the next cycle.
- The pending-clear interaction follows from this: a read of a register whose pending bit is cleared this cycle stalls one cycle.

Test Plan:
- Reset: assert rst mid-cycle -> rdata_o=0, stallreq_o=0 and pending_o=0 asynchronously. After release, a read of x5 returns 0.
- Write/read: WB writes x3=0xDEADBEEF. Next cycle, port 1 reads x3 with no forwarding hits -> 0xDEADBEEF, stall=0. A WB write to x0 of 0x1234 -> a read of x0 returns 0.
- Priority: EX, MEM and WB all target x7 with 0x11/0x22/0x33, none a load -> all ports read 0x11. Drop EX -> 0x22.
- Load-use: ex_load_i=1 on x9 and port 0 reads x9 -> stallreq_o=1. The same case via the MEM stage -> 1. Port 0 reading x10 instead -> 0.
- Scoreboard: lsu_issue_i on x12, then read x12 for 5 cycles -> stall=1 each cycle. WB with wb_load_i=1, x12=0xCAFE -> stall=0, rdata=0xCAFE, and pending_o[12] clears on the next edge.
- Set/clear collision: lsu_issue_i on x4 in the same cycle as a WB load clear of x4 -> pending_o[4]=1 afterwards. Without REGFILE_WB_BYPASS_EN, reading the WB address -> one stall cycle.
